// File: rtl/xbutton_ctrl.sv
// Push-button event controller for the picoVersat peripheral bus.
// Four buttons produce sticky press/long flags, saturating press counters and a maskable irq.
module xbutton_ctrl #(
    parameter int DATA_W   = 32,
    parameter int LONG_CYC = 1000000,
    parameter int TMR_W    = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        btn_in,
    input  logic              sel,
    input  logic              we,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              irq
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HELD = 2'd1;
    localparam logic [1:0] ST_LONG = 2'd2;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(LONG_CYC - 1);

    localparam logic [1:0] A_STATUS = 2'd0;
    localparam logic [1:0] A_MASK   = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;
    localparam logic [1:0] A_CTRL   = 2'd3;

    logic [3:0]  btn_s;
    logic [3:0]  btn_d;
    logic [3:0]  press_flag;
    logic [3:0]  long_flag;
    logic [3:0]  press_set;
    logic [3:0]  long_set;
    logic [7:0]  mask;
    logic        enable;
    logic [31:0] count_all;

    logic wr;
    logic wr_status;
    logic wr_mask;
    logic wr_count;
    logic wr_ctrl;

    assign wr        = sel & we;
    assign wr_status = wr && (addr == A_STATUS);
    assign wr_mask   = wr && (addr == A_MASK);
    assign wr_count  = wr && (addr == A_COUNT);
    assign wr_ctrl   = wr && (addr == A_CTRL);

    // Only the low 12 bits of write data ever reach a register.
    logic unused_data;
    assign unused_data = ^data_in[DATA_W-1:12];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s <= 4'b0;
            btn_d <= 4'b0;
        end else begin
            btn_s <= btn_in;
            btn_d <= btn_s;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_btn
            logic [1:0]       state;
            logic [TMR_W-1:0] timer;
            logic [7:0]       count;
            logic             rise;

            assign rise          = btn_s[gi] & ~btn_d[gi];
            assign press_set[gi] = enable && (state == ST_IDLE) && rise;
            assign long_set[gi]  = enable && (state == ST_HELD) && btn_s[gi] && (timer == TMR_LAST);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state <= ST_IDLE;
                    timer <= '0;
                end else if (!enable) begin
                    state <= ST_IDLE;
                end else begin
                    case (state)
                        ST_IDLE: begin
                            if (rise) begin
                                state <= ST_HELD;
                                timer <= '0;
                            end
                        end
                        ST_HELD: begin
                            if (!btn_s[gi]) begin
                                state <= ST_IDLE;
                            end else if (timer == TMR_LAST) begin
                                state <= ST_LONG;
                            end else begin
                                timer <= timer + 1'b1;
                            end
                        end
                        ST_LONG: begin
                            if (!btn_s[gi]) begin
                                state <= ST_IDLE;
                            end
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end

            // A press landing on the same edge as a COUNT write survives as a count of one.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    count <= 8'd0;
                end else if (wr_count) begin
                    count <= press_set[gi] ? 8'd1 : 8'd0;
                end else if (press_set[gi] && (count != 8'hFF)) begin
                    count <= count + 8'd1;
                end
            end

            assign count_all[8*gi +: 8] = count;
        end
    endgenerate

    // Setting a flag takes priority over a simultaneous write-one-to-clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press_flag <= 4'b0;
            long_flag  <= 4'b0;
            mask       <= 8'd0;
            enable     <= 1'b1;
        end else begin
            press_flag <= (press_flag & ~(wr_status ? data_in[7:4]  : 4'b0)) | press_set;
            long_flag  <= (long_flag  & ~(wr_status ? data_in[11:8] : 4'b0)) | long_set;
            if (wr_mask) begin
                mask <= data_in[7:0];
            end
            if (wr_ctrl) begin
                enable <= data_in[0];
            end
        end
    end

    assign irq = |({long_flag, press_flag} & mask);

    always_comb begin
        data_out = '0;
        if (sel) begin
            case (addr)
                A_STATUS: data_out[11:0] = {long_flag, press_flag, btn_s};
                A_MASK:   data_out[7:0]  = mask;
                A_COUNT:  data_out[31:0] = count_all;
                A_CTRL:   data_out[0]    = enable;
                default:  data_out       = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_xbutton_ctrl.sv
// Randomised and directed bench for xbutton_ctrl against a behavioural event model.
module tb_xbutton_ctrl;

    localparam int LC = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  btn_in;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    xbutton_ctrl #(.DATA_W(32), .LONG_CYC(LC), .TMR_W(5)) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in), .sel(sel), .we(we),
        .addr(addr), .data_in(data_in), .data_out(data_out), .irq(irq)
    );

    always #5 clk = ~clk;

    // Model: levels, sticky flags, counters and the age of the current qualified hold.
    logic [3:0] m_s, m_d, m_p, m_l;
    logic [7:0] m_mask;
    logic       m_en;
    int         m_cnt [4];
    int         m_age [4];

    function automatic void model_reset();
        m_s = 4'b0; m_d = 4'b0; m_p = 4'b0; m_l = 4'b0;
        m_mask = 8'd0; m_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0;
            m_age[i] = -1;
        end
    endfunction

    function automatic void model_edge();
        logic [3:0] ps, ls, clr_p, clr_l;
        logic       w;
        w  = sel && we;
        ps = 4'b0;
        ls = 4'b0;
        for (int i = 0; i < 4; i++) begin
            ps[i] = m_en && m_s[i] && !m_d[i];
            if (m_age[i] >= 0) begin
                if (!m_en || !m_s[i]) begin
                    m_age[i] = -1;
                end else begin
                    m_age[i] = m_age[i] + 1;
                    if (m_age[i] == LC) begin
                        ls[i] = 1'b1;
                        m_age[i] = -1;
                    end
                end
            end
            if (ps[i]) m_age[i] = 0;
            if (w && addr == 2'd2) m_cnt[i] = ps[i] ? 1 : 0;
            else if (ps[i] && m_cnt[i] < 255) m_cnt[i] = m_cnt[i] + 1;
        end
        clr_p = (w && addr == 2'd0) ? data_in[7:4]  : 4'b0;
        clr_l = (w && addr == 2'd0) ? data_in[11:8] : 4'b0;
        m_p = (m_p & ~clr_p) | ps;
        m_l = (m_l & ~clr_l) | ls;
        if (w && addr == 2'd1) m_mask = data_in[7:0];
        if (w && addr == 2'd3) m_en = data_in[0];
        m_d = m_s;
        m_s = btn_in;
    endfunction

    function automatic logic [31:0] exp_read();
        logic [31:0] r;
        r = 32'd0;
        if (sel) begin
            case (addr)
                2'd0: r = {20'd0, m_l, m_p, m_s};
                2'd1: r = {24'd0, m_mask};
                2'd2: r = {8'(m_cnt[3]), 8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[0])};
                default: r = {31'd0, m_en};
            endcase
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("irq_model", {31'd0, irq}, {31'd0, |({m_l, m_p} & m_mask)});
        check("read_model", data_out, exp_read());
    end

    task automatic cycle();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; data_in = d;
        cycle();
        sel = 1'b0; we = 1'b0; data_in = 32'd0;
    endtask

    task automatic read_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        sel = 1'b1; we = 1'b0; addr = a;
        #1;
        $display("read %s addr=%0d data=0x%08h", name, a, data_out);
        check(name, data_out, exp);
        sel = 1'b0;
    endtask

    // Hold a button for hold_cyc edges and report the first edge index at which the bit appears.
    task automatic hold_and_find(input logic [3:0] b, input int hold_cyc, input int bitpos, output int first);
        first = -1;
        btn_in = b;
        for (int n = 0; n < hold_cyc; n++) begin
            cycle();
            sel = 1'b1; we = 1'b0; addr = 2'd0;
            #1;
            if (first < 0 && data_out[bitpos]) first = n;
        end
        sel = 1'b0;
        btn_in = 4'b0;
    endtask

    int first;

    initial begin
        rst = 1'b1; btn_in = 4'b0; sel = 1'b0; we = 1'b0; addr = 2'd0; data_in = 32'd0;
        model_reset();
        repeat (3) cycle();
        rst = 1'b0;
        cycle();

        read_chk("reset_status", 2'd0, 32'h0);
        read_chk("reset_mask",   2'd1, 32'h0);
        read_chk("reset_count",  2'd2, 32'h0);
        read_chk("reset_ctrl",   2'd3, 32'h1);
        check("reset_irq", {31'd0, irq}, 32'd0);

        bus_write(2'd1, 32'h01);
        btn_in = 4'b0001;
        repeat (5) cycle();
        btn_in = 4'b0000;
        repeat (3) cycle();
        read_chk("pulse_status", 2'd0, 32'h010);
        read_chk("pulse_count",  2'd2, 32'h1);
        check("pulse_irq", {31'd0, irq}, 32'd1);
        bus_write(2'd0, 32'h010);
        read_chk("w1c_status", 2'd0, 32'h0);
        check("w1c_irq", {31'd0, irq}, 32'd0);

        bus_write(2'd1, 32'h0);
        hold_and_find(4'b0100, 20, 10, first);
        repeat (3) cycle();
        $display("long hold: long flag first seen at edge k+%0d", first);
        check("long_edge", 32'(first), 32'd17);
        read_chk("long_status", 2'd0, 32'h440);
        bus_write(2'd0, 32'hFF0);
        hold_and_find(4'b0100, 15, 10, first);
        repeat (20) cycle();
        check("short_no_long", 32'(first), 32'hFFFF_FFFF);
        read_chk("short_status", 2'd0, 32'h040);

        bus_write(2'd2, 32'h0);
        for (int i = 0; i < 300; i++) begin
            btn_in = 4'b0010; cycle();
            btn_in = 4'b0000; cycle();
        end
        repeat (2) cycle();
        read_chk("count_sat", 2'd2, 32'h0000FF00);
        btn_in = 4'b0010;
        cycle();
        bus_write(2'd2, 32'h0);
        btn_in = 4'b0000;
        cycle();
        read_chk("count_wr_press", 2'd2, 32'h00000100);

        bus_write(2'd0, 32'hFF0);
        btn_in = 4'b0001;
        cycle();
        bus_write(2'd0, 32'h010);
        btn_in = 4'b0000;
        cycle();
        read_chk("set_beats_w1c", 2'd0, 32'h010);

        bus_write(2'd3, 32'h0);
        bus_write(2'd0, 32'hFF0);
        btn_in = 4'b1000;
        repeat (2) cycle();
        read_chk("dis_level", 2'd0, 32'h008);
        btn_in = 4'b0000;
        repeat (2) cycle();
        read_chk("dis_status", 2'd0, 32'h000);
        read_chk("dis_count",  2'd2, 32'h00000101);
        bus_write(2'd3, 32'h1);

        btn_in = 4'b1000;
        repeat (10) cycle();
        rst = 1'b1;
        model_reset();
        repeat (2) cycle();
        read_chk("rst_status", 2'd0, 32'h0);
        read_chk("rst_count",  2'd2, 32'h0);
        rst = 1'b0;
        hold_and_find(4'b1000, 20, 11, first);
        $display("after reset: long flag first seen at edge +%0d", first);
        check("rst_long_edge", 32'(first), 32'd17);
        read_chk("rst_press_count", 2'd2, 32'h01000000);
        repeat (3) cycle();

        for (int t = 0; t < 4000; t++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(11, 0) == 0) btn_in[b] = ~btn_in[b];
            end
            sel     = $urandom_range(1, 0) == 1;
            we      = sel && ($urandom_range(3, 0) == 0);
            addr    = 2'($urandom_range(3, 0));
            data_in = $urandom;
            if (addr == 2'd3) data_in[0] = $urandom_range(3, 0) != 0;
            if ($urandom_range(1999, 0) == 0) begin
                rst = 1'b1;
                model_reset();
                cycle();
                rst = 1'b0;
            end
            cycle();
        end
        sel = 1'b0; we = 1'b0;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
